// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous word RAM between port A (CPU) and port B (DMA).
// Optional DMEM_ALIGN_CHECK_EN adds a_err/b_err and suppresses misaligned accesses.
module dmem_arbiter #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [31:0]   a_addr,
  input  logic [31:0]   a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [31:0]   a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [31:0]   b_addr,
  input  logic [31:0]   b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [31:0]   b_rdata,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic          a_err,
  output logic          b_err,
`endif
  output logic          busy
);

  localparam int NP = 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  logic [NP-1:0]       req_v, we_v;
  logic [NP-1:0][31:0] addr_v, wdata_v;

  assign req_v   = {b_req, a_req};
  assign we_v    = {b_we, a_we};
  assign addr_v  = {b_addr, a_addr};
  assign wdata_v = {b_wdata, a_wdata};

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [NP-1:0]       gnt_q, gnt_d;
  logic [NP-1:0]       rvalid_q, rvalid_d;
  logic [NP-1:0]       err_q, err_d;
  logic [NP-1:0][31:0] rdata_q, rdata_d;
  logic                mem_ren_q, mem_ren_d;
  logic                mem_wen_q, mem_wen_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                pick, mis;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // On a tie the port that did not win last time goes; otherwise the lone requester.
    pick        = (&req_v) ? ~last_q : req_v[1];
    mis         = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis         = |addr_v[pick][1:0];
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_v) begin
          owner_d      = pick;
          gnt_d[pick]  = 1'b1;
          err_d[pick]  = mis;
          mem_ren_d    = ~we_v[pick] & ~mis;
          mem_wen_d    = we_v[pick] & ~mis;
          mem_addr_d   = addr_v[pick][AW+1:2];
          mem_wdata_d  = wdata_v[pick];
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        last_d  = owner_q;
        // Only a genuine read needs the response cycle.
        state_d = mem_ren_q ? S_RESP : S_IDLE;
      end
      S_RESP: begin
        rdata_d[owner_q]  = mem_rdata;
        rvalid_d[owner_q] = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign a_gnt     = gnt_q[0];
  assign b_gnt     = gnt_q[1];
  assign a_rvalid  = rvalid_q[0];
  assign b_rvalid  = rvalid_q[1];
  assign a_rdata   = rdata_q[0];
  assign b_rdata   = rdata_q[1];
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  assign a_err = err_q[0];
  assign b_err = err_q[1];
`else
  logic unused_err;
  assign unused_err = |err_q;
`endif

  // Address bits outside the word index are intentionally dropped (wrap modulo DEPTH).
  logic unused_addr;
  assign unused_addr = ^{a_addr[31:AW+2], a_addr[1:0], b_addr[31:AW+2], b_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level reference model predicts grants,
// memory traffic and read data; a negedge monitor pops and compares.
module tb_dmem_arbiter;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, mem_ren, mem_wen, busy;
  logic [31:0] a_rdata, b_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
`ifdef DMEM_ALIGN_CHECK_EN
  logic a_err, b_err;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DMEM_ALIGN_CHECK_EN
    .a_err(a_err), .b_err(b_err),
`endif
    .busy(busy)
  );

  // Synchronous single-port RAM
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_addr];
  end

  typedef struct { int tag; int port; bit we; bit err; int word; logic [31:0] wdata; } gexp_t;
  typedef struct { int tag; int port; logic [31:0] data; } rexp_t;

  gexp_t       gq[$];
  rexp_t       rq[$];
  int          gnt_log[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd [2];
  int cyc = 0, free_at = 0, last = 1;
  int checks = 0, passes = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
  endfunction

  // Reference model: one access per grant, serialized; a write frees the arbiter 2 edges
  // after sampling, a read 3 edges after; read data appears 2 edges after sampling.
  initial begin
    int p; logic w; logic [31:0] ad, wd; int word; bit er;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n && cyc >= free_at && (a_req || b_req)) begin
        p    = (a_req && b_req) ? 1 - last : (b_req ? 1 : 0);
        w    = p ? b_we : a_we;
        ad   = p ? b_addr : a_addr;
        wd   = p ? b_wdata : a_wdata;
        word = int'((ad / 4) % DEPTH);
        er   = ALIGN && (ad % 4 != 0);
        gq.push_back('{cyc, p, w, er, word, wd});
        if (er || w) begin
          if (!er) ref_mem[word] = wd;
          free_at = cyc + 2;
        end else begin
          rq.push_back('{cyc + 2, p, ref_mem[word]});
          free_at = cyc + 3;
        end
        last = p;
      end
    end
  end

  // Monitor
  initial begin
    gexp_t g; rexp_t r; bit hg, hr; logic [1:0] eg, er;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ctl", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_ren, mem_wen, busy}), 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("rst_err", 32'({a_err, b_err}), 0);
`endif
      end else begin
        eg = 0; er = 0; hg = 0; hr = 0;
        if (gq.size() > 0 && gq[0].tag == cyc) begin
          g = gq.pop_front(); hg = 1; eg[g.port] = 1'b1; gnt_log.push_back(g.port);
        end
        chk("gnt", 32'({b_gnt, a_gnt}), 32'(eg));
        if (hg) begin
          chk("mem_ren", 32'(mem_ren), 32'(!g.we && !g.err));
          chk("mem_wen", 32'(mem_wen), 32'(g.we && !g.err));
          chk("mem_addr", 32'(mem_addr), 32'(g.word));
          if (g.we && !g.err) chk("mem_wdata", mem_wdata, g.wdata);
        end else begin
          chk("mem_idle", 32'({mem_ren, mem_wen}), 0);
        end
`ifdef DMEM_ALIGN_CHECK_EN
        chk("err", 32'({b_err, a_err}), (hg && g.err) ? 32'(eg) : 0);
`endif
        chk("ren_wen_excl", 32'(mem_ren && mem_wen), 0);
        if (rq.size() > 0 && rq[0].tag == cyc) begin
          r = rq.pop_front(); hr = 1; er[r.port] = 1'b1; last_rd[r.port] = r.data;
        end
        chk("rvalid", 32'({b_rvalid, a_rvalid}), 32'(er));
        chk("a_rdata", a_rdata, last_rd[0]);
        chk("b_rdata", b_rdata, last_rd[1]);
        chk("rv_gnt_overlap", 32'((b_rvalid && a_gnt) || (a_rvalid && b_gnt)), 0);
        chk("busy", 32'(busy), 32'(cyc <= free_at - 2));
      end
    end
  end

  task automatic set_port(input int p, input logic rq_, input logic we, input logic [31:0] ad, wd);
    if (p == 0) begin a_req = rq_; a_we = we; a_addr = ad; a_wdata = wd; end
    else        begin b_req = rq_; b_we = we; b_addr = ad; b_wdata = wd; end
  endtask

  // Hold a request until granted; a 'drop' request is withdrawn after one sampling edge.
  task automatic drive(input int p, input logic we, input logic [31:0] ad, wd, input bit drop);
    bit got = 0;
    set_port(p, 1'b1, we, ad, wd);
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if ((p == 0) ? a_gnt : b_gnt) got = 1;
      if (drop) break;
    end
    if (p == 0) a_req = 1'b0; else b_req = 1'b0;
    if (!drop) chk("gnt_wait", 32'(got), 1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; a_req = 0; b_req = 0;
    gq.delete(); rq.delete();
    free_at = 0; last = 1; last_rd[0] = 0; last_rd[1] = 0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] r;
    r = $urandom;
    r[AW+1:2] = ($urandom_range(0, 3) == 0) ? 7'(127 - $urandom_range(0, 3)) : 7'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom;
      ram[i] = v; ref_mem[i] = v;
    end
    last_rd[0] = 0; last_rd[1] = 0;
    do_reset(3);

    // Write then read back through port A
    drive(0, 1'b1, 32'h28, 32'h55AA55AA, 0);
    drive(0, 1'b0, 32'h28, 32'h0, 0);
    idle(4);

    // Both ports hold reads from reset: grants must alternate starting with A
    do_reset(2);
    gnt_log.delete();
    fork
      for (int i = 0; i < 4; i++) drive(0, 1'b0, 32'(i * 4), 32'h0, 0);
      for (int i = 0; i < 4; i++) drive(1, 1'b0, 32'(64 + i * 4), 32'h0, 0);
    join
    idle(4);
    chk("alt_count", 32'(gnt_log.size()), 8);
    for (int i = 0; i < gnt_log.size(); i++) chk("alt_order", 32'(gnt_log[i]), 32'(i % 2));

    // B write wraps to word 0; A reads it back
    drive(1, 1'b1, 32'h200, 32'hCAFEF00D, 0);
    drive(0, 1'b0, 32'h0, 32'h0, 0);
    idle(4);

    // Reset during the response cycle of an A read; next tie goes to A
    drive(0, 1'b0, 32'h40, 32'h0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk("t4_busy", 32'(busy), 0);
    do_reset(2);
    gnt_log.delete();
    fork
      drive(0, 1'b1, 32'h44, 32'h11112222, 0);
      drive(1, 1'b1, 32'h48, 32'h33334444, 0);
    join
    idle(3);
    chk("t4_first_a", 32'(gnt_log[0]), 0);

    // Back-to-back write/read on A with B idle
    drive(0, 1'b1, 32'h60, 32'hDEADBEEF, 0);
    drive(0, 1'b0, 32'h60, 32'h0, 0);
    idle(4);

    // Misaligned write, then aligned read of the same word
    drive(0, 1'b1, 32'h2A, 32'h12345678, 0);
    drive(0, 1'b0, 32'h28, 32'h0, 0);
    idle(4);

    // Randomized concurrent traffic with occasional withdrawn requests
    fork
      for (int i = 0; i < 120; i++) begin
        idle($urandom_range(0, 3));
        drive(0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, $urandom_range(0, 9) == 0);
      end
      for (int i = 0; i < 120; i++) begin
        idle($urandom_range(0, 3));
        drive(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, $urandom_range(0, 9) == 0);
      end
    join

    for (int i = 0; i < 20 && (gq.size() > 0 || rq.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    chk("drain", 32'(gq.size() + rq.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
